seq_pc_status: RTL
==================

# seq_pc_status

Architectural state register for the Y86-64 SEQ processor, sitting directly downstream of the combinational status-update logic and the execute/memory stages. Each enabled clock edge it commits the next PC, latches the final instruction status, and counts retired instructions and executed cycles. Once a non-AOK status is committed it freezes all state and asserts `halted`.

## Interface
Parameters:
- `PC_W`, 64: width of PC, valC, valM, valP.
- `CNT_W`, 32: width of the instruction and cycle counters.

Ports:
- `clk`  in  1  processor clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  commit enable; 0 holds all state, including the cycle counter.
- `icode`  in  4  instruction code of the current instruction.
- `cnd`  in  1  branch condition from execute.
- `valC`  in  PC_W  constant word from fetch.
- `valM`  in  PC_W  word read from memory.
- `valP`  in  PC_W  fall-through PC from fetch.
- `status_in`  in  2  final status of the current instruction, from status update.
- `pc`  out  PC_W  committed PC; drives fetch.
- `stat`  out  2  committed processor status.
- `halted`  out  1  `stat != AOK`.
- `instr_count`  out  CNT_W  retired instructions.
- `cycle_count`  out  CNT_W  enabled cycles while running.

## Operation
- Status encoding: AOK=0, HLT=1, ADR=2, INS=3.
- icodes: HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B.
- Next-PC selection:
  - CALL -> valC.
  - JXX with cnd=1 -> valC.
  - RET -> valM.
  - Otherwise, including JXX with cnd=0 and undefined icodes -> valP.
- The block has two states, RUN (`stat == AOK`) and STOP (`stat != AOK`).
- RUN with `en=1`, per edge:
  - `cycle_count` += 1.
  - `stat` <= `status_in`.
  - If `status_in == AOK`: `pc` <= next-PC and `instr_count` += 1.
  - If `status_in == HLT`: `pc` holds, pointing at the halt instruction, and `instr_count` += 1 because halt retires.
  - If `status_in` is ADR or INS: `pc` holds, pointing at the faulting instruction, and `instr_count` does not increment.
- STOP: every input is ignored and all registers hold. The only exit is `reset`.
- `en=0`: all registers hold in either state.
- Counters wrap modulo 2^CNT_W with no saturation or flag.
- PC arithmetic: none. Next-PC is a pure select of PC_W-bit values.

## Timing
- Reset values: `pc`=0, `stat`=AOK, `halted`=0, `instr_count`=0, `cycle_count`=0.
- `reset` has priority over `en` and over every other input.
- Reset asserted mid-run or in STOP returns the block to RUN with the reset values on the next edge.
- All outputs except `halted` are registered and change only at rising `clk`.
- `halted` is decoded combinationally from the `stat` register, so it has zero added latency relative to `stat`.
- Latency: `status_in` and next-PC are sampled at edge N and visible on outputs after edge N.
- Simultaneous non-AOK `status_in` and a CALL/JXX/RET target: the status wins and `pc` holds.
- There is no combinational path from any input to any output.

## Structure
- Shared package `y86_pkg`:
  - Status codes AOK/HLT/ADR/INS as 2-bit constants.
  - icode constants as 4-bit values.
  - This package is shared with fetch, decode and status update.
- Sub-module `seq_next_pc`: a combinational next-PC select from (icode, cnd, valC, valM, valP), also reusable by the PIPE PC-predict logic.
- Top level holds the registers and the RUN/STOP control.

## Test plan
- Reset, then `en=1`, `icode=1`, `valP=0x2`, AOK for 3 edges -> `pc`=0x2, `instr_count`=3, `cycle_count`=3, `halted`=0.
- CALL `valC=0x100`, then JXX `cnd=0` `valP=0x109`, then JXX `cnd=1` `valC=0x40`, then RET `valM=0x200`, all AOK -> `pc` sequence 0x100, 0x109, 0x40, 0x200.
- At `pc=0x40`, `status_in=HLT`, `icode=0` -> `stat`=1, `halted`=1, `pc`=0x40, `instr_count` +1. Then 5 further edges with AOK inputs and CALL `valC=0x999` -> no register changes.
- `status_in=ADR` with CALL `valC=0x80` -> `stat`=2, `pc` unchanged, `instr_count` unchanged, `cycle_count` +1. Repeat with INS -> `stat`=3.
- `en=0` for 4 edges with varying inputs -> all outputs hold. Assert `reset` while halted with `stat`=3 -> next edge `pc`=0, `stat`=0, both counts=0.
- `CNT_W=4`: 16 AOK NOPs -> `instr_count` wraps to 0 and `cycle_count` wraps to 0, with no other effect.

Source files
------------

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 definitions used by fetch, decode, status update and the
// SEQ architectural state register.
//   - 2-bit processor status codes
//   - 4-bit instruction codes
//   - RUN/STOP control state type for the commit register
// ---------------------------------------------------------------------------
package y86_pkg;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } run_state_t;

    function automatic logic is_running(input logic [1:0] stat);
        return stat == STAT_AOK;
    endfunction

endpackage

// File: rtl/seq_next_pc.sv
// ---------------------------------------------------------------------------
// seq_next_pc
// Combinational next-PC select for the SEQ processor; also usable by the
// PIPE PC-predict logic. Pure mux, no arithmetic.
// Ports:
//   icode   in  4     instruction code
//   cnd     in  1     branch condition from execute
//   valC    in  PC_W  constant word (call/jump target)
//   valM    in  PC_W  word read from memory (return address)
//   valP    in  PC_W  fall-through PC
//   pc_next out PC_W  selected next PC
// ---------------------------------------------------------------------------
module seq_next_pc
    import y86_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [3:0]      icode,
    input  logic            cnd,
    input  logic [PC_W-1:0] valC,
    input  logic [PC_W-1:0] valM,
    input  logic [PC_W-1:0] valP,
    output logic [PC_W-1:0] pc_next
);

    always_comb begin
        pc_next = valP;
        case (icode)
            ICODE_CALL: pc_next = valC;
            ICODE_JXX:  pc_next = cnd ? valC : valP;
            ICODE_RET:  pc_next = valM;
            default:    pc_next = valP;
        endcase
    end

endmodule

// File: rtl/seq_pc_status.sv
// ---------------------------------------------------------------------------
// seq_pc_status
// SEQ architectural state register: commits next PC and final status,
// counts retired instructions and enabled running cycles, and freezes once
// a non-AOK status is committed until reset.
// Ports:
//   clk          in  1      processor clock
//   reset        in  1      synchronous active-high reset
//   en           in  1      commit enable
//   icode        in  4      current instruction code
//   cnd          in  1      branch condition
//   valC/valM/valP in PC_W  next-PC candidates
//   status_in    in  2      final status of current instruction
//   pc           out PC_W   committed PC
//   stat         out 2      committed status
//   halted       out 1      stat != AOK
//   instr_count  out CNT_W  retired instructions
//   cycle_count  out CNT_W  enabled running cycles
//
// state | meaning
// ------+----------------------------------------------------------
// RUN   | stat == AOK; enabled edges commit pc/stat and count
// STOP  | stat != AOK; all registers frozen until reset
//
// The control state is not a separate register: it is decoded from the
// committed stat, so RUN/STOP can never disagree with the visible status.
// ---------------------------------------------------------------------------
module seq_pc_status
    import y86_pkg::*;
#(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       icode,
    input  logic             cnd,
    input  logic [PC_W-1:0]  valC,
    input  logic [PC_W-1:0]  valM,
    input  logic [PC_W-1:0]  valP,
    input  logic [1:0]       status_in,
    output logic [PC_W-1:0]  pc,
    output logic [1:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    run_state_t       state_cur;
    logic [PC_W-1:0]  pc_target;
    logic [PC_W-1:0]  pc_nxt;
    logic [1:0]       stat_nxt;
    logic [CNT_W-1:0] instr_nxt;
    logic [CNT_W-1:0] cycle_nxt;

    seq_next_pc #(
        .PC_W (PC_W)
    ) u_next_pc (
        .icode   (icode),
        .cnd     (cnd),
        .valC    (valC),
        .valM    (valM),
        .valP    (valP),
        .pc_next (pc_target)
    );

    assign state_cur = is_running(stat) ? RUN : STOP;
    assign halted    = (state_cur == STOP);

    always_comb begin
        pc_nxt    = pc;
        stat_nxt  = stat;
        instr_nxt = instr_count;
        cycle_nxt = cycle_count;
        if (en && state_cur == RUN) begin
            cycle_nxt = cycle_count + CNT_W'(1);
            stat_nxt  = status_in;
            case (status_in)
                STAT_AOK: begin
                    pc_nxt    = pc_target;
                    instr_nxt = instr_count + CNT_W'(1);
                end
                // halt retires but pc stays on the halt instruction
                STAT_HLT: instr_nxt = instr_count + CNT_W'(1);
                // ADR/INS: faulting instruction does not retire
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            stat        <= STAT_AOK;
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            pc          <= pc_nxt;
            stat        <= stat_nxt;
            instr_count <= instr_nxt;
            cycle_count <= cycle_nxt;
        end
    end

endmodule
